// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs the EX/MEM entry's load/store against a handshaked
// data memory, stalls upstream while the access is pending, emits MEM/WB entries.
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  alu_result_in,
  input  logic [DATA_W-1:0]  rs_data_in,
  input  logic [RADDR_W-1:0] rd_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic               reg_write_in,
  output logic               stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic               wb_valid,
  output logic [DATA_W-1:0]  wb_data,
  output logic [RADDR_W-1:0] wb_rd,
  output logic               wb_reg_write,
  output logic               mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [CNT_W-1:0]    r_count;
  logic [RADDR_W-1:0]  r_rd;
  logic                r_regWrite;
  logic                r_req;
  logic                r_we;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wbValid;
  logic [DATA_W-1:0]   r_wbData;
  logic [RADDR_W-1:0]  r_wbRd;
  logic                r_wbRegWrite;
  logic                r_memErr;
  logic                w_memOp;
  logic                w_expire;
  logic                w_stall;

  assign w_memOp  = mem_read_in | mem_write_in;
  assign w_expire = (r_count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (r_state == ST_IDLE) begin
      if (w_memOp) begin
        w_nextState = ST_WAIT;
      end
    end else begin
      if (dmem_ack || w_expire) begin
        w_nextState = ST_IDLE;
      end
    end
  end

  // Upstream is released on the ack (or expiry) cycle itself so the next entry
  // is loaded on the same edge that retires the access.
  always_comb begin
    w_stall = 1'b0;
    if (r_state == ST_IDLE) begin
      w_stall = w_memOp;
    end else begin
      w_stall = !dmem_ack && !w_expire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_rd         <= '0;
      r_regWrite   <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wbValid    <= 1'b0;
      r_wbData     <= '0;
      r_wbRd       <= '0;
      r_wbRegWrite <= 1'b0;
      r_memErr     <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (!w_memOp) begin
        r_wbValid    <= 1'b1;
        r_wbData     <= alu_result_in;
        r_wbRd       <= rd_in;
        r_wbRegWrite <= reg_write_in;
      end else begin
        // A load+store entry is issued as a store and never writes a register.
        r_req        <= 1'b1;
        r_we         <= mem_write_in;
        r_addr       <= alu_result_in;
        r_wdata      <= rs_data_in;
        r_rd         <= rd_in;
        r_regWrite   <= reg_write_in & ~mem_write_in;
        r_wbValid    <= 1'b0;
        r_wbRegWrite <= 1'b0;
        r_count      <= '0;
      end
    end else begin
      if (dmem_ack) begin
        r_req     <= 1'b0;
        r_wbValid <= 1'b1;
        r_wbRd    <= r_rd;
        if (r_we) begin
          r_wbData     <= r_addr;
          r_wbRegWrite <= 1'b0;
        end else begin
          r_wbData     <= dmem_rdata;
          r_wbRegWrite <= r_regWrite;
        end
      end else if (w_expire) begin
        r_req        <= 1'b0;
        r_memErr     <= 1'b1;
        r_wbValid    <= 1'b1;
        r_wbData     <= r_addr;
        r_wbRd       <= r_rd;
        r_wbRegWrite <= 1'b0;
      end else begin
        r_count      <= r_count + CNT_W'(1);
        r_wbValid    <= 1'b0;
        r_wbRegWrite <= 1'b0;
      end
    end
  end

  assign stall        = w_stall;
  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_wdata;
  assign wb_valid     = r_wbValid;
  assign wb_data      = r_wbData;
  assign wb_rd        = r_wbRd;
  assign wb_reg_write = r_wbRegWrite;
  assign mem_err      = r_memErr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: memory responder model plus a write-back scoreboard.
module tb_mem_access_stage;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] alu_result_in = '0;
  logic [DW-1:0] rs_data_in = '0;
  logic [RW-1:0] rd_in = '0;
  logic          mem_read_in = 1'b0;
  logic          mem_write_in = 1'b0;
  logic          reg_write_in = 1'b0;
  logic          stall;
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_ack = 1'b0;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [RW-1:0] wb_rd;
  logic          wb_reg_write;
  logic          mem_err;

  mem_access_stage #(.DATA_W(DW), .RADDR_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result_in(alu_result_in), .rs_data_in(rs_data_in), .rd_in(rd_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [RW-1:0] rd;
    logic          rw;
    bit            full;
  } wbExp_t;

  wbExp_t expQ[$];
  wbExp_t monEntry;
  int errors = 0;
  int checks = 0;

  int            ackDelay = -1;
  logic [DW-1:0] respData = '0;
  bit            forceAck = 1'b0;
  int            reqCycles = 0;
  int            lastReqLen = 0;
  int            issueCount = 0;
  logic          lastWe = 1'b0;
  logic [DW-1:0] lastAddr = '0;
  logic [DW-1:0] lastWdata = '0;

  // Memory model: acks after ackDelay request cycles and checks request stability.
  always @(negedge clk) begin
    if (dmem_req) begin
      if (reqCycles == 0) begin
        issueCount++;
        lastWe    = dmem_we;
        lastAddr  = dmem_addr;
        lastWdata = dmem_wdata;
      end else begin
        checks++;
        if ({dmem_we, dmem_addr, dmem_wdata} !== {lastWe, lastAddr, lastWdata}) begin
          errors++;
          $display("[TB] FAIL req_stable got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                   dmem_we, dmem_addr, dmem_wdata, lastWe, lastAddr, lastWdata);
        end
      end
      dmem_ack   = forceAck || (ackDelay >= 0 && reqCycles == ackDelay);
      dmem_rdata = respData;
      reqCycles++;
    end else begin
      if (reqCycles != 0) lastReqLen = reqCycles;
      reqCycles  = 0;
      dmem_ack   = forceAck;
      dmem_rdata = respData;
    end
  end

  // Scoreboard: every valid write-back entry must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (wb_valid) begin
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL wb_unexpected got data=%h rd=%0d rw=%b", wb_data, wb_rd, wb_reg_write);
        end else begin
          monEntry = expQ.pop_front();
          if (wb_reg_write !== monEntry.rw ||
              (monEntry.full && (wb_data !== monEntry.data || wb_rd !== monEntry.rd))) begin
            errors++;
            $display("[TB] FAIL wb_entry got data=%h rd=%0d rw=%b want data=%h rd=%0d rw=%b",
                     wb_data, wb_rd, wb_reg_write, monEntry.data, monEntry.rd, monEntry.rw);
          end
        end
      end else if (wb_reg_write !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wb_rw_when_invalid got %b want 0", wb_reg_write);
      end
    end
  end

  // Presents one EX/MEM entry (called at negedge+1) and holds it until consumed.
  task automatic sendInstr(input logic [DW-1:0] alu, input logic [DW-1:0] rs,
                           input logic [RW-1:0] rd, input logic rdEn, input logic wrEn,
                           input logic rwEn, input bit timeoutExp, output int stallCnt);
    wbExp_t e;
    logic s;
    bit done;
    alu_result_in = alu;
    rs_data_in    = rs;
    rd_in         = rd;
    mem_read_in   = rdEn;
    mem_write_in  = wrEn;
    reg_write_in  = rwEn;
    e.rd   = rd;
    e.full = 1'b1;
    if (!(rdEn || wrEn)) begin
      e.data = alu;
      e.rw   = rwEn;
    end else if (timeoutExp) begin
      e.data = '0;
      e.rw   = 1'b0;
      e.full = 1'b0;
    end else if (wrEn) begin
      e.data = alu;
      e.rw   = 1'b0;
    end else begin
      e.data = respData;
      e.rw   = rwEn;
    end
    expQ.push_back(e);
    stallCnt = 0;
    done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      s = stall;
      @(negedge clk);
      #1;
      if (!s) begin
        done = 1'b1;
        break;
      end
      stallCnt++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL consume_timeout got stall held 64 cycles want release");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checks += 8;
    if (dmem_req !== 1'b0)     begin errors++; $display("[TB] FAIL rst_req got %b want 0", dmem_req); end
    if (dmem_we !== 1'b0)      begin errors++; $display("[TB] FAIL rst_we got %b want 0", dmem_we); end
    if (dmem_addr !== '0)      begin errors++; $display("[TB] FAIL rst_addr got %h want 0", dmem_addr); end
    if (wb_valid !== 1'b0)     begin errors++; $display("[TB] FAIL rst_wb_valid got %b want 0", wb_valid); end
    if (wb_data !== '0)        begin errors++; $display("[TB] FAIL rst_wb_data got %h want 0", wb_data); end
    if (wb_reg_write !== 1'b0) begin errors++; $display("[TB] FAIL rst_wb_rw got %b want 0", wb_reg_write); end
    if (mem_err !== 1'b0)      begin errors++; $display("[TB] FAIL rst_mem_err got %b want 0", mem_err); end
    if (stall !== 1'b0)        begin errors++; $display("[TB] FAIL rst_stall got %b want 0", stall); end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_passthrough();
    int sc;
    sendInstr(16'h1234, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, sc);
    checks++;
    if (sc !== 0) begin errors++; $display("[TB] FAIL alu_stall got %0d want 0", sc); end
    sendInstr(16'hFFFF, 16'h5555, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, sc);
    sendInstr(16'h0001, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, sc);
    checks++;
    if (sc !== 0) begin errors++; $display("[TB] FAIL alu2_stall got %0d want 0", sc); end
  endtask

  task automatic test_load();
    int sc;
    int startIssue;
    startIssue = issueCount;
    ackDelay = 3;
    respData = 16'hBEEF;
    sendInstr(16'h0040, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, sc);
    checks += 4;
    if (sc !== 4)             begin errors++; $display("[TB] FAIL load_stall got %0d want 4", sc); end
    if (lastReqLen !== 4)     begin errors++; $display("[TB] FAIL load_req_len got %0d want 4", lastReqLen); end
    if (lastWe !== 1'b0)      begin errors++; $display("[TB] FAIL load_we got %b want 0", lastWe); end
    if (lastAddr !== 16'h0040) begin errors++; $display("[TB] FAIL load_addr got %h want 0040", lastAddr); end
    sendInstr(16'h0ABC, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, sc);
    checks++;
    if (issueCount - startIssue !== 1) begin
      errors++; $display("[TB] FAIL load_issues got %0d want 1", issueCount - startIssue);
    end
  endtask

  task automatic test_store();
    int sc;
    int startIssue;
    startIssue = issueCount;
    ackDelay = 0;
    sendInstr(16'h0010, 16'hA5A5, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, sc);
    sendInstr(16'h2222, 16'h0000, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, sc);
    checks += 5;
    if (lastReqLen !== 1)       begin errors++; $display("[TB] FAIL store_req_len got %0d want 1", lastReqLen); end
    if (lastWe !== 1'b1)        begin errors++; $display("[TB] FAIL store_we got %b want 1", lastWe); end
    if (lastWdata !== 16'hA5A5) begin errors++; $display("[TB] FAIL store_wdata got %h want a5a5", lastWdata); end
    if (lastAddr !== 16'h0010)  begin errors++; $display("[TB] FAIL store_addr got %h want 0010", lastAddr); end
    if (issueCount - startIssue !== 1) begin
      errors++; $display("[TB] FAIL store_reissue got %0d issues want 1", issueCount - startIssue);
    end
  endtask

  task automatic test_both_flags();
    int sc;
    ackDelay = 1;
    sendInstr(16'h0030, 16'h1357, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, sc);
    checks += 2;
    if (lastWe !== 1'b1) begin errors++; $display("[TB] FAIL both_we got %b want 1", lastWe); end
    if (sc !== 2)        begin errors++; $display("[TB] FAIL both_stall got %0d want 2", sc); end
  endtask

  task automatic test_back_to_back();
    int sc1;
    int sc2;
    int startIssue;
    startIssue = issueCount;
    ackDelay = 0;
    respData = 16'h1111;
    sendInstr(16'h0100, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, sc1);
    respData = 16'h2222;
    sendInstr(16'h0102, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, sc2);
    checks += 3;
    if (sc1 !== 1) begin errors++; $display("[TB] FAIL b2b_stall1 got %0d want 1", sc1); end
    if (sc2 !== 1) begin errors++; $display("[TB] FAIL b2b_stall2 got %0d want 1", sc2); end
    if (issueCount - startIssue !== 2) begin
      errors++; $display("[TB] FAIL b2b_issues got %0d want 2", issueCount - startIssue);
    end
  endtask

  task automatic test_timeout();
    int sc;
    ackDelay = -1;
    sendInstr(16'h0080, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, sc);
    checks += 3;
    if (sc !== TO)         begin errors++; $display("[TB] FAIL to_stall got %0d want %0d", sc, TO); end
    if (lastReqLen !== TO) begin errors++; $display("[TB] FAIL to_req_len got %0d want %0d", lastReqLen, TO); end
    if (mem_err !== 1'b1)  begin errors++; $display("[TB] FAIL to_mem_err got %b want 1", mem_err); end
    sendInstr(16'h4321, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, sc);
    checks += 2;
    if (sc !== 0)         begin errors++; $display("[TB] FAIL to_next_stall got %0d want 0", sc); end
    if (mem_err !== 1'b1) begin errors++; $display("[TB] FAIL to_sticky got %b want 1", mem_err); end
  endtask

  task automatic test_async_reset();
    int sc;
    int startIssue;
    ackDelay = -1;
    alu_result_in = 16'h0090;
    rd_in         = 3'd5;
    mem_read_in   = 1'b1;
    mem_write_in  = 1'b0;
    reg_write_in  = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL ar_req_before got %b want 1", dmem_req); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (dmem_req !== 1'b0)     begin errors++; $display("[TB] FAIL ar_req got %b want 0", dmem_req); end
    if (wb_valid !== 1'b0)     begin errors++; $display("[TB] FAIL ar_wb_valid got %b want 0", wb_valid); end
    if (wb_reg_write !== 1'b0) begin errors++; $display("[TB] FAIL ar_wb_rw got %b want 0", wb_reg_write); end
    if (mem_err !== 1'b0)      begin errors++; $display("[TB] FAIL ar_mem_err got %b want 0", mem_err); end
    forceAck = 1'b1;
    respData = 16'hDEAD;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    startIssue = issueCount;
    sendInstr(16'h7777, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, sc);
    sendInstr(16'h7778, 16'h0000, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, sc);
    forceAck = 1'b0;
    checks += 3;
    if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL stray_req got %b want 0", dmem_req); end
    if (issueCount !== startIssue) begin
      errors++; $display("[TB] FAIL stray_issue got %0d want %0d", issueCount, startIssue);
    end
    if (mem_err !== 1'b0) begin errors++; $display("[TB] FAIL stray_mem_err got %b want 0", mem_err); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    #1;
    test_reset();
    test_alu_passthrough();
    test_load();
    test_store();
    test_both_flags();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    sendInstr(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, lastReqLen);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending want 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
